// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one burst memory port between two requesters
// Read beats are routed back through an in-order tag FIFO of {requester, beat count}.
module mem_port_arbiter #(
  parameter int BURST_WIDTH   = 8,
  parameter int PENDING_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rest,
  input  logic [31:0]            s0_address,
  input  logic [3:0]             s0_byteEnable,
  input  logic                   s0_read,
  input  logic                   s0_write,
  input  logic [31:0]            s0_writeData,
  input  logic [BURST_WIDTH-1:0] s0_burstCount,
  input  logic                   s0_beginBurstTransfer,
  output logic                   s0_waitRequest,
  output logic [31:0]            s0_readData,
  output logic                   s0_readDataValid,
  input  logic [31:0]            s1_address,
  input  logic [3:0]             s1_byteEnable,
  input  logic                   s1_read,
  input  logic                   s1_write,
  input  logic [31:0]            s1_writeData,
  input  logic [BURST_WIDTH-1:0] s1_burstCount,
  input  logic                   s1_beginBurstTransfer,
  output logic                   s1_waitRequest,
  output logic [31:0]            s1_readData,
  output logic                   s1_readDataValid,
  output logic [31:0]            m0_address,
  output logic [3:0]             m0_byteEnable,
  output logic                   m0_read,
  output logic                   m0_write,
  output logic [31:0]            m0_writeData,
  output logic [BURST_WIDTH-1:0] m0_burstCount,
  output logic                   m0_beginBurstTransfer,
  input  logic [31:0]            m0_readData,
  input  logic                   m0_waitRequest,
  input  logic                   m0_readDataValid
);
  localparam int PW = (PENDING_DEPTH > 1) ? $clog2(PENDING_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [BURST_WIDTH-1:0] ONE = BURST_WIDTH'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1, WBURST = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic                   grant_q, grant_d;
  logic                   last_grant_q, last_grant_d;
  logic [BURST_WIDTH-1:0] wrem_q, wrem_d;
  logic [BURST_WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   tag_q   [PENDING_DEPTH];
  logic                   tag_d   [PENDING_DEPTH];
  logic [BURST_WIDTH-1:0] beats_q [PENDING_DEPTH];
  logic [BURST_WIDTH-1:0] beats_d [PENDING_DEPTH];

  logic [31:0]            s_address, s_writeData;
  logic [3:0]             s_byteEnable;
  logic                   s_read, s_write, s_bbt;
  logic [BURST_WIDTH-1:0] s_burstCount, s_beats;
  logic                   owned, in_own, fifo_full, fifo_empty, gwait;
  logic                   rd_acc, wr_acc, beat, last_beat, head_tag, nxt;
  logic [BURST_WIDTH-1:0] head_beats;

  assign s_address    = grant_q ? s1_address            : s0_address;
  assign s_byteEnable = grant_q ? s1_byteEnable         : s0_byteEnable;
  assign s_read       = grant_q ? s1_read               : s0_read;
  assign s_write      = grant_q ? s1_write              : s0_write;
  assign s_writeData  = grant_q ? s1_writeData          : s0_writeData;
  assign s_burstCount = grant_q ? s1_burstCount         : s0_burstCount;
  assign s_bbt        = grant_q ? s1_beginBurstTransfer : s0_beginBurstTransfer;
  assign s_beats      = (s_burstCount == '0) ? ONE : s_burstCount;

  assign owned      = (state_q != IDLE);
  assign in_own     = (state_q == OWN);
  assign fifo_full  = (count_q == CW'(PENDING_DEPTH));
  assign fifo_empty = (count_q == '0);

  assign m0_address            = s_address;
  assign m0_byteEnable         = s_byteEnable;
  assign m0_writeData          = s_writeData;
  assign m0_burstCount         = s_burstCount;
  assign m0_beginBurstTransfer = s_bbt;
  // Reads only start from OWN; a simultaneous read+write issues the read.
  assign m0_read  = in_own & s_read & ~fifo_full;
  assign m0_write = owned & s_write & ~(in_own & s_read);

  assign gwait          = m0_waitRequest | (in_own & s_read & fifo_full);
  assign s0_waitRequest = (owned & ~grant_q) ? gwait : 1'b1;
  assign s1_waitRequest = (owned &  grant_q) ? gwait : 1'b1;

  assign rd_acc = m0_read  & ~m0_waitRequest;
  assign wr_acc = m0_write & ~m0_waitRequest;

  assign head_tag   = tag_q[rd_ptr_q];
  assign head_beats = beats_q[rd_ptr_q];
  assign beat       = m0_readDataValid & ~fifo_empty;
  assign last_beat  = beat & (cnt_q == head_beats - ONE);

  assign s0_readData      = m0_readData;
  assign s1_readData      = m0_readData;
  assign s0_readDataValid = beat & ~head_tag;
  assign s1_readDataValid = beat &  head_tag;

  assign nxt = ~last_grant_q;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    wrem_d       = wrem_q;
    cnt_d        = cnt_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    tag_d        = tag_q;
    beats_d      = beats_q;
    count_d      = count_q + CW'(rd_acc) - CW'(last_beat);

    case (state_q)
      IDLE: begin
        if (s0_read | s0_write | s1_read | s1_write) begin
          // Prefer the requester that did not win last time.
          if (nxt ? (s1_read | s1_write) : (s0_read | s0_write)) begin
            grant_d = nxt;
          end else begin
            grant_d = last_grant_q;
          end
          last_grant_d = grant_d;
          state_d      = OWN;
        end
      end
      OWN: begin
        if (rd_acc) begin
          tag_d[wr_ptr_q]   = grant_q;
          beats_d[wr_ptr_q] = s_beats;
          wr_ptr_d          = wr_ptr_q + PW'(1);
          state_d           = IDLE;
        end else if (wr_acc) begin
          if (s_beats > ONE) begin
            wrem_d  = s_beats - ONE;
            state_d = WBURST;
          end else begin
            state_d = IDLE;
          end
        end else if (!s_read && !s_write) begin
          state_d = IDLE;
        end
      end
      WBURST: begin
        if (wr_acc) begin
          wrem_d = wrem_q - ONE;
          if (wrem_q == ONE) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (last_beat) begin
      cnt_d    = '0;
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else if (beat) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      wrem_q       <= '0;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      for (int i = 0; i < PENDING_DEPTH; i++) begin
        tag_q[i]   <= 1'b0;
        beats_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      wrem_q       <= wrem_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      tag_q        <= tag_d;
      beats_q      <= beats_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
// The memory model returns word (address << 4) for every read beat address.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rest;
  always #5 clk = ~clk;

  logic [31:0] s_address [2];
  logic [3:0]  s_be      [2];
  logic        s_read    [2];
  logic        s_write   [2];
  logic [31:0] s_wdata   [2];
  logic [7:0]  s_bc      [2];
  logic        s_bbt     [2];
  logic        s_wait    [2];
  logic [31:0] s_rdata   [2];
  logic        s_rvalid  [2];

  logic [31:0] m0_address, m0_writeData, m0_readData;
  logic [3:0]  m0_byteEnable;
  logic [7:0]  m0_burstCount;
  logic        m0_read, m0_write, m0_beginBurstTransfer;
  logic        m0_waitRequest, m0_readDataValid;

  mem_port_arbiter #(.BURST_WIDTH(8), .PENDING_DEPTH(4)) dut (
    .clk(clk), .rest(rest),
    .s0_address(s_address[0]), .s0_byteEnable(s_be[0]), .s0_read(s_read[0]),
    .s0_write(s_write[0]), .s0_writeData(s_wdata[0]), .s0_burstCount(s_bc[0]),
    .s0_beginBurstTransfer(s_bbt[0]), .s0_waitRequest(s_wait[0]),
    .s0_readData(s_rdata[0]), .s0_readDataValid(s_rvalid[0]),
    .s1_address(s_address[1]), .s1_byteEnable(s_be[1]), .s1_read(s_read[1]),
    .s1_write(s_write[1]), .s1_writeData(s_wdata[1]), .s1_burstCount(s_bc[1]),
    .s1_beginBurstTransfer(s_bbt[1]), .s1_waitRequest(s_wait[1]),
    .s1_readData(s_rdata[1]), .s1_readDataValid(s_rvalid[1]),
    .m0_address(m0_address), .m0_byteEnable(m0_byteEnable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writeData(m0_writeData), .m0_burstCount(m0_burstCount),
    .m0_beginBurstTransfer(m0_beginBurstTransfer), .m0_readData(m0_readData),
    .m0_waitRequest(m0_waitRequest), .m0_readDataValid(m0_readDataValid)
  );

  typedef struct {
    bit          wr;
    int          id;
    int          cyc;
    logic [31:0] data;
    logic [7:0]  bc;
    logic [3:0]  be;
  } acc_t;

  typedef struct {
    int          n;
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  bc;
    logic [3:0]  be;
    int          exp_beats;
    int          exp_acc;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          rcv [2];
  int          wr_acc_cnt = 0;
  bit          mem_hold = 1'b0;
  bit          abort = 1'b0;
  logic [31:0] mq [$];
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];
  int          beat_cyc0 [$];
  int          beat_cyc1 [$];
  acc_t        log_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=handshake", name);
  endtask

  // Memory model and monitor: drive at negedge, sample 2 units later.
  initial begin
    rcv[0] = 0;
    rcv[1] = 0;
    m0_readDataValid = 1'b0;
    m0_readData = 32'h0;
    forever begin
      @(negedge clk);
      m0_readDataValid = (mq.size() > 0) && !mem_hold;
      m0_readData = (mq.size() > 0) ? mq[0] : 32'h0;
      #2;
      cyc++;
      if (m0_readDataValid) void'(mq.pop_front());
      if (s_rvalid[0] || s_rvalid[1]) chk("both_valid", {31'h0, s_rvalid[0] & s_rvalid[1]}, 32'h0);
      if (s_rvalid[0]) begin
        rcv[0]++;
        beat_cyc0.push_back(cyc);
        if (exp_q0.size() == 0) chk("unexpected_beat0", s_rdata[0], 32'hxxxx_xxxx);
        else chk("rdata0", s_rdata[0], exp_q0.pop_front());
      end
      if (s_rvalid[1]) begin
        rcv[1]++;
        beat_cyc1.push_back(cyc);
        if (exp_q1.size() == 0) chk("unexpected_beat1", s_rdata[1], 32'hxxxx_xxxx);
        else chk("rdata1", s_rdata[1], exp_q1.pop_front());
      end
      if (rest && (m0_read || m0_write) && !m0_waitRequest) begin
        acc_t a;
        a.wr = m0_write && !m0_read;
        a.id = int'(m0_address[12]);
        a.cyc = cyc;
        a.data = m0_writeData;
        a.bc = m0_burstCount;
        a.be = m0_byteEnable;
        log_q.push_back(a);
        if (a.wr) wr_acc_cnt++;
        if (m0_read) begin
          for (int i = 0; i < ((m0_burstCount == 0) ? 1 : int'(m0_burstCount)); i++)
            mq.push_back((m0_address + 32'(i * 4)) << 4);
        end
      end
    end
  end

  task automatic rd(input int n, input logic [31:0] addr, input logic [7:0] bc,
                    input logic [3:0] be, output int lat);
    int eb;
    eb = (bc == 0) ? 1 : int'(bc);
    @(negedge clk);
    s_read[n] = 1'b1; s_write[n] = 1'b0; s_address[n] = addr; s_bc[n] = bc; s_be[n] = be;
    for (int i = 0; i < eb; i++) begin
      if (n == 0) exp_q0.push_back((addr + 32'(i * 4)) << 4);
      else exp_q1.push_back((addr + 32'(i * 4)) << 4);
    end
    lat = 0;
    #1;
    while (s_wait[n]) begin
      if (lat >= 200) begin
        timeout_fail("rd_timeout");
        break;
      end
      @(negedge clk);
      #1;
      lat++;
    end
    @(posedge clk);
  endtask

  task automatic wr(input int n, input logic [31:0] addr, input logic [7:0] bc, input logic [3:0] be);
    int eb;
    int t;
    eb = (bc == 0) ? 1 : int'(bc);
    @(negedge clk);
    s_write[n] = 1'b1; s_read[n] = 1'b0; s_address[n] = addr; s_bc[n] = bc; s_be[n] = be;
    for (int b = 0; b < eb; b++) begin
      s_wdata[n] = addr + 32'(b);
      s_bbt[n] = (b == 0);
      #1;
      t = 0;
      while (s_wait[n] && !abort) begin
        if (t >= 200) begin
          timeout_fail("wr_timeout");
          break;
        end
        @(negedge clk);
        #1;
        t++;
      end
      if (abort || t >= 200) break;
      @(posedge clk);
      @(negedge clk);
    end
    s_write[n] = 1'b0;
    s_bbt[n] = 1'b0;
  endtask

  task automatic drop(input int n);
    @(negedge clk);
    s_read[n] = 1'b0;
    s_write[n] = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      #3;
      if (mq.size() == 0 && exp_q0.size() == 0 && exp_q1.size() == 0) break;
    end
    chk("drain_pending", 32'(mq.size() + exp_q0.size() + exp_q1.size()), 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rest = 1'b0;
    mq.delete();
    exp_q0.delete();
    exp_q1.delete();
    repeat (2) @(negedge clk);
    rest = 1'b1;
  endtask

  task automatic wait_first_write(input int w0);
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      #3;
      if (wr_acc_cnt > w0) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    vec_t tbl [6];
    int   lat, l0, r0, r1, w0, nacc;

    tbl[0] = '{0, 1'b0, 32'h0000_0050, 8'd1, 4'hf, 1, 1};
    tbl[1] = '{1, 1'b0, 32'h0000_1060, 8'd0, 4'h3, 1, 1};
    tbl[2] = '{0, 1'b0, 32'h0000_0070, 8'd3, 4'hc, 3, 1};
    tbl[3] = '{1, 1'b1, 32'h0000_1080, 8'd1, 4'h1, 0, 1};
    tbl[4] = '{0, 1'b1, 32'h0000_0090, 8'd0, 4'hf, 0, 1};
    tbl[5] = '{1, 1'b0, 32'h0000_10a0, 8'd2, 4'h6, 2, 1};

    rest = 1'b0;
    m0_waitRequest = 1'b0;
    for (int n = 0; n < 2; n++) begin
      s_address[n] = 32'h0; s_be[n] = 4'h0; s_read[n] = 1'b0; s_write[n] = 1'b0;
      s_wdata[n] = 32'h0; s_bc[n] = 8'h0; s_bbt[n] = 1'b0;
    end
    repeat (3) @(negedge clk);
    s_read[0] = 1'b1;
    s_write[1] = 1'b1;
    #1;
    chk("rst_m0_read", {31'h0, m0_read}, 32'h0);
    chk("rst_m0_write", {31'h0, m0_write}, 32'h0);
    chk("rst_s0_wait", {31'h0, s_wait[0]}, 32'h1);
    chk("rst_s1_wait", {31'h0, s_wait[1]}, 32'h1);
    chk("rst_valid", {30'h0, s_rvalid[1], s_rvalid[0]}, 32'h0);
    s_read[0] = 1'b0;
    s_write[1] = 1'b0;
    @(negedge clk);
    rest = 1'b1;

    // Single read from s0 straight after reset.
    r0 = rcv[0]; r1 = rcv[1];
    rd(0, 32'h10, 8'd1, 4'hf, lat);
    chk("t1_latency", 32'(lat), 32'd1);
    drop(0);
    drain();
    chk("t1_s0_beats", 32'(rcv[0] - r0), 32'd1);
    chk("t1_s1_beats", 32'(rcv[1] - r1), 32'd0);

    for (int v = 0; v < 6; v++) begin
      l0 = log_q.size();
      r0 = rcv[tbl[v].n];
      if (tbl[v].wr) begin
        wr(tbl[v].n, tbl[v].addr, tbl[v].bc, tbl[v].be);
        nacc = (tbl[v].bc == 0) ? 1 : int'(tbl[v].bc);
      end else begin
        rd(tbl[v].n, tbl[v].addr, tbl[v].bc, tbl[v].be, lat);
        chk("tbl_latency", 32'(lat), 32'(tbl[v].exp_acc));
        nacc = 1;
      end
      drop(tbl[v].n);
      drain();
      chk("tbl_accepts", 32'(log_q.size() - l0), 32'(nacc));
      if (log_q.size() > l0) begin
        chk("tbl_id", 32'(log_q[l0].id), 32'(tbl[v].n));
        chk("tbl_kind", {31'h0, log_q[l0].wr}, {31'h0, tbl[v].wr});
        chk("tbl_bc", {24'h0, log_q[l0].bc}, {24'h0, tbl[v].bc});
        chk("tbl_be", {28'h0, log_q[l0].be}, {28'h0, tbl[v].be});
        if (tbl[v].wr) chk("tbl_wdata", log_q[l0].data, tbl[v].addr);
      end
      chk("tbl_beats", 32'(rcv[tbl[v].n] - r0), 32'(tbl[v].exp_beats));
    end

    // Both requesters read continuously: grants alternate starting with s0.
    do_reset();
    l0 = log_q.size(); r0 = rcv[0]; r1 = rcv[1];
    fork
      begin
        for (int i = 0; i < 8; i++) rd(0, 32'h100 + 32'(i * 16), 8'd1, 4'hf, lat);
        drop(0);
      end
      begin
        for (int i = 0; i < 8; i++) rd(1, 32'h1000 + 32'(i * 16), 8'd1, 4'hf, lat);
        drop(1);
      end
    join
    drain();
    chk("t2_accepts", 32'(log_q.size() - l0), 32'd16);
    for (int i = 0; i < 16 && (l0 + i) < log_q.size(); i++)
      chk("t2_grant_order", 32'(log_q[l0 + i].id), 32'(i % 2));
    chk("t2_s0_beats", 32'(rcv[0] - r0), 32'd8);
    chk("t2_s1_beats", 32'(rcv[1] - r1), 32'd8);

    // s1 write burst of 4 with a 3-cycle stall on beat 2, s0 reading meanwhile.
    do_reset();
    l0 = log_q.size(); r0 = rcv[0]; w0 = wr_acc_cnt;
    fork
      wr(1, 32'h1000, 8'd4, 4'hf);
      begin
        @(negedge clk);
        rd(0, 32'h20, 8'd1, 4'hf, lat);
        drop(0);
      end
      begin
        wait_first_write(w0);
        @(negedge clk);
        m0_waitRequest = 1'b1;
        repeat (3) @(negedge clk);
        m0_waitRequest = 1'b0;
      end
    join
    drain();
    chk("t3_accepts", 32'(log_q.size() - l0), 32'd5);
    if (log_q.size() >= l0 + 5) begin
      for (int b = 0; b < 4; b++) begin
        chk("t3_wr_kind", {31'h0, log_q[l0 + b].wr}, 32'h1);
        chk("t3_wr_id", 32'(log_q[l0 + b].id), 32'd1);
        chk("t3_wr_data", log_q[l0 + b].data, 32'h1000 + 32'(b));
      end
      chk("t3_stall_gap", 32'(log_q[l0 + 1].cyc - log_q[l0].cyc), 32'd4);
      chk("t3_rd_kind", {31'h0, log_q[l0 + 4].wr}, 32'h0);
      chk("t3_rd_id", 32'(log_q[l0 + 4].id), 32'd0);
      chk("t3_bubble", 32'(log_q[l0 + 4].cyc - log_q[l0 + 3].cyc), 32'd2);
    end
    chk("t3_s0_beats", 32'(rcv[0] - r0), 32'd1);

    // Memory withholds read data: the 5th read must wait for the first return.
    do_reset();
    l0 = log_q.size(); r0 = rcv[0];
    beat_cyc0.delete();
    fork
      begin
        for (int i = 0; i < 6; i++) rd(0, 32'h200 + 32'(i * 16), 8'd1, 4'hf, lat);
        drop(0);
      end
      begin
        mem_hold = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        chk("t4_accepted_while_held", 32'(log_q.size() - l0), 32'd4);
        chk("t4_s0_wait", {31'h0, s_wait[0]}, 32'h1);
        chk("t4_m0_read", {31'h0, m0_read}, 32'h0);
        mem_hold = 1'b0;
      end
    join
    drain();
    chk("t4_s0_beats", 32'(rcv[0] - r0), 32'd6);
    if (log_q.size() >= l0 + 5 && beat_cyc0.size() > 0)
      chk("t4_fifth_after_return", 32'(log_q[l0 + 4].cyc - beat_cyc0[0]), 32'd1);
    else
      chk("t4_fifth_seen", 32'(log_q.size() - l0), 32'd6);

    // Burst read of 8 for s0, then a single read for s1.
    do_reset();
    r0 = rcv[0]; r1 = rcv[1];
    beat_cyc0.delete();
    beat_cyc1.delete();
    rd(0, 32'h300, 8'd8, 4'hf, lat);
    drop(0);
    rd(1, 32'h1100, 8'd1, 4'hf, lat);
    drop(1);
    drain();
    chk("t5_s0_beats", 32'(rcv[0] - r0), 32'd8);
    chk("t5_s1_beats", 32'(rcv[1] - r1), 32'd1);
    if (beat_cyc0.size() == 8 && beat_cyc1.size() == 1)
      chk("t5_order", {31'h0, beat_cyc1[0] > beat_cyc0[7]}, 32'h1);
    r0 = rcv[0]; r1 = rcv[1];
    mq.push_back(32'hdead_0000);
    repeat (3) @(negedge clk);
    #3;
    chk("t5_stray_dropped", 32'((rcv[0] - r0) + (rcv[1] - r1)), 32'd0);

    // Reset asserted on beat 2 of a 4-beat write burst.
    do_reset();
    w0 = wr_acc_cnt;
    fork
      wr(1, 32'h1200, 8'd4, 4'hf);
      begin
        wait_first_write(w0);
        @(negedge clk);
        #1;
        rest = 1'b0;
        abort = 1'b1;
        #1;
        chk("t6_m0_read", {31'h0, m0_read}, 32'h0);
        chk("t6_m0_write", {31'h0, m0_write}, 32'h0);
        chk("t6_s0_wait", {31'h0, s_wait[0]}, 32'h1);
        chk("t6_s1_wait", {31'h0, s_wait[1]}, 32'h1);
        chk("t6_valid", {30'h0, s_rvalid[1], s_rvalid[0]}, 32'h0);
      end
    join
    chk("t6_writes_before_reset", 32'(wr_acc_cnt - w0), 32'd1);
    mq.delete();
    @(negedge clk);
    rest = 1'b1;
    abort = 1'b0;
    r0 = rcv[0]; r1 = rcv[1];
    mq.push_back(32'hbeef_0000);
    repeat (3) @(negedge clk);
    #3;
    chk("t6_stray_dropped", 32'((rcv[0] - r0) + (rcv[1] - r1)), 32'd0);
    rd(0, 32'h40, 8'd1, 4'hf, lat);
    chk("t6_latency", 32'(lat), 32'd1);
    drop(0);
    drain();
    chk("t6_s0_beats", 32'(rcv[0] - r0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
